buffer_arbiter: RTL and testbench

// Shares one single-port BUFFER memory between NUM_REQ requesters using valid/ready handshakes.

---
 rtl/buffer_arbiter.sv | 128 ++++++++++++
 tb/tb_buffer_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_arbiter.sv
// Round-robin arbiter sharing one single-port BUFFER among NUM_REQ requesters.
// Bounded burst lock, registered BUFFER pins, one-hot read-data return.
module buffer_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOCK   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_cen,
    output logic                          mem_wen,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam bit LOCK_EN = (MAX_LOCK > 1);
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [IW-1:0] gnt_id;
    logic          hs;
    logic [IW-1:0] pend_id;
    logic          pend_rd;

    // Grant: owner only while locked, otherwise first valid after last_grant.
    always_comb begin
        gnt_id    = '0;
        hs        = 1'b0;
        req_ready = '0;
        if (state_q == LOCKED) begin
            if (req_valid[owner_q]) begin
                hs     = 1'b1;
                gnt_id = owner_q;
            end
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (!hs && req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
                    hs     = 1'b1;
                    gnt_id = IW'((int'(last_grant) + i) % NUM_REQ);
                end
            end
        end
        req_ready[gnt_id] = hs;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB: begin
                if (LOCK_EN && hs && req_lock[gnt_id]) begin
                    state_d    = LOCKED;
                    owner_d    = gnt_id;
                    lock_cnt_d = CW'(1);
                end
            end
            LOCKED: begin
                if (hs) begin
                    if (!req_lock[owner_q] ||
                        lock_cnt_q == CW'(MAX_LOCK - 1)) begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            last_grant <= LAST_ID;
            mem_cen    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pend_id    <= '0;
            pend_rd    <= 1'b0;
            rsp_valid  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            mem_cen    <= hs;
            pend_rd    <= hs && !req_wen[gnt_id];
            rsp_valid  <= '0;
            if (pend_rd) begin
                rsp_valid[pend_id] <= 1'b1;
            end
            if (hs) begin
                last_grant <= gnt_id;
                mem_wen    <= req_wen[gnt_id];
                mem_addr   <= req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata  <= req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
                pend_id    <= gnt_id;
            end
        end
    end

    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter: BUFFER model plus read scoreboard.
// Directed grant sequences with per-cycle expected grants.
module tb_buffer_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int ML = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wen = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_cen;
    logic            mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    buffer_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] exp_mem [0:255];

    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
            else         mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct {
        int            due;
        logic [N-1:0]  oh;
        logic [DW-1:0] data;
    } rd_t;

    rd_t q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    logic          prev_hs = 1'b0;
    logic          prev_wen = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            check("rsp_valid", 32'(rsp_valid), 32'(q[0].oh));
            check("rsp_rdata", 32'(rsp_rdata), 32'(q[0].data));
            void'(q.pop_front());
        end else if (rsp_valid != '0) begin
            check("rsp_spurious", 32'(rsp_valid), 32'd0);
        end
    end

    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [1:0] lk,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] exp_rdy, input string tag);
        logic [15:0] a, d;
        logic        g;
        req_valid = v;
        req_wen   = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        check({tag, "_cen"}, 32'(mem_cen), 32'(prev_hs));
        if (prev_hs) begin
            check({tag, "_addr"}, 32'(mem_addr), 32'(prev_addr));
            check({tag, "_wen"}, 32'(mem_wen), 32'(prev_wen));
            if (prev_wen) check({tag, "_wdata"}, 32'(mem_wdata), 32'(prev_wdata));
        end
        prev_hs = |(v & exp_rdy);
        if (prev_hs) begin
            g          = exp_rdy[1];
            a          = g ? a1 : a0;
            d          = g ? d1 : d0;
            prev_addr  = a;
            prev_wdata = d;
            prev_wen   = we[g];
            if (we[g]) exp_mem[a[7:0]] = d;
            else q.push_back('{cyc + 2, exp_rdy, exp_mem[a[7:0]]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, tag);
    endtask

    task automatic do_reset();
        q.delete();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cen", 32'(mem_cen), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        rst     = 1'b0;
        prev_hs = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        for (int i = 0; i < 4; i++)
            step(2'b11, 2'b11, 2'b00, 16'h10 + 16'(i), 16'h11 + 16'(i),
                 16'hA000 + 16'(i), 16'hB000 + 16'(i),
                 (i % 2 == 0) ? 2'b01 : 2'b10, "rr");
        idle("rr_idle");

        step(2'b01, 2'b01, 2'b00, 16'h3, 16'h0, 16'hA5A5, 16'h0, 2'b01, "wr3");
        step(2'b10, 2'b00, 2'b00, 16'h0, 16'h3, 16'h0, 16'h0, 2'b10, "rd3");
        repeat (3) idle("rd3_idle");

        for (int i = 0; i < 9; i++)
            step(2'b11, 2'b11, 2'b01, 16'h20 + 16'(i), 16'h30,
                 16'h1000 + 16'(i), 16'hBEEF,
                 (i < ML) ? 2'b01 : 2'b10, "lockmax");
        idle("lockmax_idle");

        step(2'b11, 2'b11, 2'b01, 16'h40, 16'h41, 16'h4040, 16'h4141, 2'b01, "lk_go");
        repeat (3)
            step(2'b10, 2'b11, 2'b01, 16'h40, 16'h41, 16'h4040, 16'h4141, 2'b00, "lk_hold");
        step(2'b11, 2'b11, 2'b00, 16'h42, 16'h41, 16'h4242, 16'h4141, 2'b01, "lk_end");
        step(2'b10, 2'b11, 2'b00, 16'h42, 16'h41, 16'h4242, 16'h4141, 2'b10, "lk_after");
        idle("lk_idle");

        step(2'b01, 2'b00, 2'b00, 16'h3, 16'h0, 16'h0, 16'h0, 2'b01, "rst_rd");
        do_reset();
        step(2'b11, 2'b11, 2'b00, 16'h50, 16'h51, 16'h5050, 16'h5151, 2'b01, "post_rst");
        idle("post_rst_idle");

        step(2'b01, 2'b01, 2'b00, 16'h1, 16'h0, 16'h1111, 16'h0, 2'b01, "wr1");
        step(2'b10, 2'b10, 2'b00, 16'h0, 16'h2, 16'h0, 16'h2222, 2'b10, "wr2");
        for (int i = 0; i < 4; i++)
            step(2'b11, 2'b00, 2'b00, 16'h1, 16'h2, 16'h0, 16'h0,
                 (i % 2 == 0) ? 2'b01 : 2'b10, "alt_rd");

        for (int i = 0; i < 6 && q.size() > 0; i++) idle("drain");
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
